// File: rtl/ad7771_config_sequencer.sv
// ============================================================================
// ad7771_config_sequencer
// ----------------------------------------------------------------------------
// Purpose:
//   Brings the AD7771 up after FPGA configuration. On a start request it
//   pulses the ADC /RESET pin and waits for the ADC to power up. It then
//   writes a fixed table of registers over the ADC SPI control port, with
//   this block acting as SPI master in mode 3. When the whole table has been
//   written cleanly, dout_enable_o is raised so the DOUT sample reader can
//   start capturing.
//
// Optional build macro:
//   AD7771_CFG_READBACK_EN
//     When defined, every write frame is followed by a read frame to the same
//     address. The returned byte is compared with the written data. On a
//     mismatch the sticky error_o is set and the sequence stops in DONE with
//     dout_enable_o low. When undefined, no read frames are issued, error_o is
//     tied to 0 and sdi_i is unused.
//
// Parameters:
//   NUM_REGS            number of 16-bit entries in cfg_table_i (1..32)
//   CLK_DIV             SCLK half-period in clk_i cycles (2..255)
//   RESET_PULSE_CYCLES  width of the adc_reset_no low pulse (>= 1)
//   POWERUP_WAIT_CYCLES delay from adc_reset_no rising to the first frame (>= 1)
//
// Ports:
//   clk_i          FPGA clock
//   reset_ni       asynchronous active-low reset
//   start_i        single-cycle request to run the sequence (ignored while busy)
//   cfg_table_i    entry k at [16k+15:16k], sent in order k = 0 first;
//                  bit 15 is forced to 0 (write), [14:8] address, [7:0] data
//   busy_o         high while the sequence is running (not IDLE / DONE)
//   done_o         high in DONE
//   error_o        sticky readback-mismatch flag (readback build only)
//   dout_enable_o  high in DONE when no error occurred
//   adc_reset_no   ADC /RESET
//   cs_no          ADC /CS
//   sclk_o         ADC SCLK (idles high)
//   sdo_o          FPGA -> ADC SDI, changes on SCLK falling edges, MSB first
//   sdi_i          ADC SDO -> FPGA, passed through a 2-flop synchroniser
//
// Timing (all outputs are registered):
//   Each frame: CS_SETUP (CLK_DIV) + SHIFT (32*CLK_DIV) + CS_HOLD (CLK_DIV)
//   keeps cs_no low for exactly 34*CLK_DIV cycles, and GAP adds 2*CLK_DIV
//   with cs_no high, so one frame costs 36*CLK_DIV cycles.
//
//   Counting the cycle in which start_i is sampled as cycle 1, done_o is
//   first seen high after exactly
//       1 + RESET_PULSE_CYCLES + POWERUP_WAIT_CYCLES + F*36*CLK_DIV
//   cycles, where F is the number of frames sent:
//       F = NUM_REGS                   (default build)
//       F = 2*NUM_REGS                 (readback build, no mismatch)
//       F = 2*(index of failing entry + 1)  (readback build, mismatch)
//   Each state's duration already includes its exit transition, so no extra
//   cycles are added between states.
// ============================================================================
module ad7771_config_sequencer #(
    parameter int NUM_REGS            = 4,
    parameter int CLK_DIV             = 4,
    parameter int RESET_PULSE_CYCLES  = 100,
    parameter int POWERUP_WAIT_CYCLES = 20000
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     start_i,
    input  logic [NUM_REGS*16-1:0]   cfg_table_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_o,
    output logic                     dout_enable_o,
    output logic                     adc_reset_no,
    output logic                     cs_no,
    output logic                     sclk_o,
    output logic                     sdo_o,
    input  logic                     sdi_i
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    // Every timed state loads (duration - 1) and leaves when the count hits 0.
    localparam logic [31:0] DIV_M1 = 32'(CLK_DIV - 1);
    localparam logic [31:0] GAP_M1 = 32'(2 * CLK_DIV - 1);
    localparam logic [31:0] RST_M1 = 32'(RESET_PULSE_CYCLES - 1);
    localparam logic [31:0] PWR_M1 = 32'(POWERUP_WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_PULSE,
        ST_PWR_WAIT,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t           state;
    logic [31:0]      cnt;
    logic [3:0]       bit_idx;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] next_idx;

    // Holds the frame bits that still have to go out after the one currently
    // on sdo_o. The MSB is driven directly when the frame starts, so only the
    // remaining 15 bits are kept here.
    logic [14:0]      shift_q;

    assign next_idx = idx + 1'b1;

    // Lower 15 bits of a write frame for entry i: address and data, with the
    // R/W bit (always 0 for a write) driven separately.
    function automatic logic [14:0] write_tail(input logic [IDX_W-1:0] i);
        return cfg_table_i[int'(i) * 16 +: 15];
    endfunction

`ifdef AD7771_CFG_READBACK_EN
    logic       read_phase;
    logic [7:0] rx_q;
    logic       sdi_meta;
    logic       sdi_sync;

    // Lower 15 bits of a read frame for entry i: same address, data zeroed.
    function automatic logic [14:0] read_tail(input logic [IDX_W-1:0] i);
        return {cfg_table_i[int'(i) * 16 + 8 +: 7], 8'h00};
    endfunction

    function automatic logic [7:0] entry_data(input logic [IDX_W-1:0] i);
        return cfg_table_i[int'(i) * 16 +: 8];
    endfunction

    // sdi_i comes straight from the ADC pin and is asynchronous to clk_i,
    // so it passes through two flops before the shifter looks at it.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sdi_meta <= 1'b0;
            sdi_sync <= 1'b0;
        end else begin
            sdi_meta <= sdi_i;
            sdi_sync <= sdi_meta;
        end
    end
`else
    // Readback is compiled out, so the ADC SDO pin has no consumer.
    logic unused_sdi;
    assign unused_sdi = sdi_i;
    assign error_o    = 1'b0;
`endif

    // Main sequencer. All pin-level outputs are updated in the same branch
    // that changes state, so every output is a plain register and changes
    // in the same cycle as the state it belongs to.
    //
    // Read data is shifted in at the end of each SCLK high phase, not
    // directly at the rising edge. The ADC drives a new bit after the falling
    // edge, and the value it presents at the rising edge needs two cycles to
    // pass through the synchroniser. Taking it CLK_DIV cycles later (with
    // CLK_DIV >= 2) picks up exactly that value and never the next bit.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            idx           <= '0;
            shift_q       <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            dout_enable_o <= 1'b0;
            adc_reset_no  <= 1'b1;
            cs_no         <= 1'b1;
            sclk_o        <= 1'b1;
            sdo_o         <= 1'b0;
`ifdef AD7771_CFG_READBACK_EN
            read_phase    <= 1'b0;
            rx_q          <= '0;
            error_o       <= 1'b0;
`endif
        end else begin
            case (state)
                // IDLE and DONE both wait for a start. Leaving DONE clears
                // the completion flags in the same cycle.
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state         <= ST_RST_PULSE;
                        cnt           <= RST_M1;
                        adc_reset_no  <= 1'b0;
                        busy_o        <= 1'b1;
                        done_o        <= 1'b0;
                        dout_enable_o <= 1'b0;
`ifdef AD7771_CFG_READBACK_EN
                        error_o       <= 1'b0;
`endif
                    end
                end

                ST_RST_PULSE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 32'd1;
                    end else begin
                        state        <= ST_PWR_WAIT;
                        cnt          <= PWR_M1;
                        adc_reset_no <= 1'b1;
                    end
                end

                // After the power-up wait, start the first write frame.
                ST_PWR_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 32'd1;
                    end else begin
                        state   <= ST_CS_SETUP;
                        cnt     <= DIV_M1;
                        idx     <= '0;
                        bit_idx <= '0;
                        cs_no   <= 1'b0;
                        sdo_o   <= 1'b0;
                        shift_q <= write_tail('0);
`ifdef AD7771_CFG_READBACK_EN
                        read_phase <= 1'b0;
`endif
                    end
                end

                // The MSB is already on sdo_o. The first SCLK fall opens bit 0.
                ST_CS_SETUP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 32'd1;
                    end else begin
                        state  <= ST_SHIFT;
                        cnt    <= DIV_M1;
                        sclk_o <= 1'b0;
                    end
                end

                // Each bit is a low half followed by a high half. The next bit
                // is put on sdo_o together with the falling edge.
                ST_SHIFT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 32'd1;
                    end else if (!sclk_o) begin
                        sclk_o <= 1'b1;
                        cnt    <= DIV_M1;
                    end else begin
`ifdef AD7771_CFG_READBACK_EN
                        rx_q <= {rx_q[6:0], sdi_sync};
`endif
                        cnt <= DIV_M1;
                        if (bit_idx == 4'd15) begin
                            state <= ST_CS_HOLD;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            sclk_o  <= 1'b0;
                            sdo_o   <= shift_q[14];
                            shift_q <= {shift_q[13:0], 1'b0};
                        end
                    end
                end

                ST_CS_HOLD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 32'd1;
                    end else begin
                        state <= ST_GAP;
                        cnt   <= GAP_M1;
                        cs_no <= 1'b1;
                    end
                end

                // End of a frame. Decide whether to issue a readback, stop on
                // a mismatch, finish the table, or move on to the next entry.
                ST_GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 32'd1;
                    end
`ifdef AD7771_CFG_READBACK_EN
                    else if (!read_phase) begin
                        state      <= ST_CS_SETUP;
                        cnt        <= DIV_M1;
                        bit_idx    <= '0;
                        cs_no      <= 1'b0;
                        sdo_o      <= 1'b1;
                        shift_q    <= read_tail(idx);
                        read_phase <= 1'b1;
                    end else if (rx_q != entry_data(idx)) begin
                        state         <= ST_DONE;
                        busy_o        <= 1'b0;
                        done_o        <= 1'b1;
                        dout_enable_o <= 1'b0;
                        error_o       <= 1'b1;
                    end
`endif
                    else if (idx == LAST_IDX) begin
                        state         <= ST_DONE;
                        busy_o        <= 1'b0;
                        done_o        <= 1'b1;
                        dout_enable_o <= 1'b1;
                    end else begin
                        state   <= ST_CS_SETUP;
                        cnt     <= DIV_M1;
                        idx     <= next_idx;
                        bit_idx <= '0;
                        cs_no   <= 1'b0;
                        sdo_o   <= 1'b0;
                        shift_q <= write_tail(next_idx);
`ifdef AD7771_CFG_READBACK_EN
                        read_phase <= 1'b0;
`endif
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ad7771_config_sequencer.md
Name: ad7771_config_sequencer

Overview:
- Brings up the AD7771 after FPGA configuration. Pulses the ADC /RESET pin, waits for power-up, then writes a fixed table of registers over the ADC's SPI control port, with the FPGA as SPI master.
- When the sequence completes cleanly, asserts `dout_enable_o`. This gates the DOUT data reader, so sample capture starts only after the ADC is configured.
- Sits between top-level start logic and the ADC control pins. The DOUT reader is not modified.

Parameters:
- `NUM_REGS`, 4, number of register writes in `cfg_table_i`; legal range 1..32.
- `CLK_DIV`, 4, SCLK half-period in `clk_i` cycles; legal range 2..255.
- `RESET_PULSE_CYCLES`, 100, width of the `adc_reset_no` low pulse in `clk_i` cycles; must be at least 1.
- `POWERUP_WAIT_CYCLES`, 20000, delay in `clk_i` cycles from `adc_reset_no` rising to the first frame.

Ports:
- `clk_i`  in  1  FPGA clock
- `reset_ni`  in  1  asynchronous, active-low reset
- `start_i`  in  1  single-cycle request to run the sequence
- `cfg_table_i`  in  `NUM_REGS*16`  entry k is at `[16k+15:16k]` and is sent first for k=0; bit 15 is ignored and forced to 0 (write); `[14:8]` is the address, `[7:0]` is the data
- `busy_o`  out  1  high whenever the FSM is not in IDLE or DONE
- `done_o`  out  1  high in DONE
- `error_o`  out  1  sticky readback mismatch flag (Optional Feature only; tied to 0 otherwise)
- `dout_enable_o`  out  1  high in DONE when `error_o` is 0
- `adc_reset_no`  out  1  ADC /RESET
- `cs_no`  out  1  ADC /CS
- `sclk_o`  out  1  ADC SCLK
- `sdo_o`  out  1  FPGA to ADC SDI
- `sdi_i`  in  1  ADC SDO to FPGA; synchronised with a 2-flop synchroniser before use

Behaviour:
- **Reset values:**
  - `busy_o`=0, `done_o`=0, `error_o`=0, `dout_enable_o`=0
  - `adc_reset_no`=1, `cs_no`=1, `sclk_o`=1, `sdo_o`=0
  - FSM state = IDLE
  - Reset mid-sequence aborts immediately to these values. No frame is completed.
- **Outputs:** all outputs are registered, with no combinational paths from inputs.
- **SPI mode 3:**
  - SCLK idles high.
  - `sdo_o` changes only on SCLK falling edges, MSB first.
  - `sdi_i` is sampled on SCLK rising edges.
- **FSM states:**
  - IDLE: on `start_i`, go to RST_PULSE.
  - RST_PULSE: `adc_reset_no`=0 for `RESET_PULSE_CYCLES` cycles, then go to PWR_WAIT.
  - PWR_WAIT: `adc_reset_no`=1 for `POWERUP_WAIT_CYCLES` cycles. Index k=0. Go to CS_SETUP.
  - CS_SETUP: `cs_no`=0 and the frame MSB is driven on `sdo_o` for `CLK_DIV` cycles. Go to SHIFT.
  - SHIFT: 16 bits. Each bit is `CLK_DIV` cycles with `sclk_o`=0 followed by `CLK_DIV` cycles with `sclk_o`=1. Go to CS_HOLD.
  - CS_HOLD: `sclk_o`=1 for `CLK_DIV` cycles. Go to GAP.
  - GAP: `cs_no`=1 for `2*CLK_DIV` cycles.
    - If k=`NUM_REGS`-1, go to DONE.
    - Otherwise increment k and go to CS_SETUP.
  - DONE: hold state. A `start_i` pulse clears `dout_enable_o`/`done_o`/`error_o` and goes to RST_PULSE.
- **Frame timing:** `cs_no` is low for exactly 34*`CLK_DIV` cycles per frame.
- **Sequence duration:** from the `start_i` cycle to `done_o` high is 1 + `RESET_PULSE_CYCLES` + `POWERUP_WAIT_CYCLES` + `NUM_REGS`*36*`CLK_DIV` cycles, with one FSM transition cycle allowed in each state.
  - This exact count is a verification constant. It must be documented in an RTL comment once the implementation is final.
- **`start_i` handling:** ignored while `busy_o`=1.
- **`cfg_table_i` sampling:** the value is sampled into the shift register at CS_SETUP entry, so changes mid-frame have no effect.
- **`dout_enable_o` timing:** falls in the same cycle the FSM leaves DONE.

Optional Feature:
- Macro: `AD7771_CFG_READBACK_EN`.
- **When defined:** after each write frame and its GAP, the FSM issues a read frame using the same timing.
  - The read frame is `{1'b1, addr[6:0], 8'h00}`.
  - Bits 7..0 sampled from the synchronised `sdi_i` form the readback byte.
  - If the byte differs from the written data, set `error_o`=1 and go straight to DONE with `dout_enable_o`=0.
  - If it matches, continue to the next entry.
  - Frames per entry: 2.
- **When undefined:** no read frames are issued, `error_o` is constantly 0, and the synchroniser is removed.

Test Plan:
1. Reset: deassert `reset_ni` with no `start_i` -> outputs hold their reset values indefinitely, and `busy_o`=0.
2. Timing: `NUM_REGS`=2, `CLK_DIV`=2, `RESET_PULSE_CYCLES`=10, `POWERUP_WAIT_CYCLES`=50, table {0x8180, 0x0011} -> `adc_reset_no` low for 10 cycles; first `cs_no` fall 50 cycles after it rises; each frame `cs_no` low for 68 cycles.
3. Frame content: same run -> bench SPI slave decodes frames 0x0180 and 0x0011 (bit 15 forced to 0). `sdo_o` is stable at every `sclk_o` rise. `done_o`=`dout_enable_o`=1 afterwards.
4. Busy/restart: `start_i` pulsed mid-SHIFT -> ignored, frame count unchanged. `start_i` pulsed in DONE -> `dout_enable_o` drops the next cycle and the full sequence repeats.
5. Async reset: assert `reset_ni` during the 8th bit of frame 1 -> `cs_no`=1, `sclk_o`=1, `busy_o`=0 with no clock edge required. No further frames until a new `start_i`.
6. Readback (`AD7771_CFG_READBACK_EN`): slave echoes 0x80 for address 0x01 and 0x10 for address 0x00 -> `error_o`=1, `done_o`=1, `dout_enable_o`=0 after the 4th frame. With a correct echo, `error_o`=0 and `dout_enable_o`=1.
